histogram_builder: RTL and testbench

HISTOGRAM_BUILDER -- requirements
Module: histogram_builder

---
 rtl/histogram_builder.sv | 186 ++++++++++++++++++
 tb/tb_histogram_builder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_builder.sv
// histogram_builder: scans PIXEL_COUNT 8-bit pixels from M1 and accumulates a
// 256-bin histogram in M2 bank {input_base_offset, bin}. Each pixel costs one
// read-modify-write of its bin, pipelined one pixel per cycle.
// Optional feature macro: HISTOGRAM_BUILDER_CLEAR_EN. When defined, the block
// zeroes all 256 bins of the selected bank before scanning. When undefined,
// start goes straight to the scan and the bins must already be zero.
// Handshake: start is a single-cycle request taken only while busy is low;
// busy stays high from acceptance through the done cycle, and done pulses once.
// The FSM state is held in state_q for observation.
`timescale 1ns/1ps
module histogram_builder #(
  parameter int PIXEL_COUNT = 65536,
  parameter int COUNT_W     = 20,
  parameter int M1_ADDR_W   = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 input_base_offset,
  input  logic [7:0]           m1_read_data,
  output logic [M1_ADDR_W-1:0] m1_read_addr,
  input  logic [COUNT_W-1:0]   m2_read_data,
  output logic [8:0]           m2_read_addr,
  output logic [8:0]           m2_write_addr,
  output logic [COUNT_W-1:0]   m2_write_data,
  output logic                 m2_write_en,
  output logic                 busy,
  output logic                 done
);

  localparam logic [M1_ADDR_W-1:0] LAST_ADDR = M1_ADDR_W'(PIXEL_COUNT - 1);
  localparam logic [COUNT_W-1:0]   COUNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Job context and issue side
  logic                 bank_q, bank_d;
  logic [7:0]           clr_cnt_q, clr_cnt_d;
  logic [7:0]           clr_k_q, clr_k_d;
  logic                 clr_we_q, clr_we_d;
  logic [M1_ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [M1_ADDR_W-1:0] m1_addr_q, m1_addr_d;

  // Pipeline: iss = M1 address presented, v1 = pixel/bin read, v2 = bin write
  logic                 iss_q, iss_d;
  logic                 v1_q, v2_q;
  logic [7:0]           pix2_q, pix2_d;
  logic                 fwd_v_q, fwd_v_d;
  logic [COUNT_W-1:0]   fwd_val_q, fwd_val_d;

  // Last driven values, so idle addresses/data hold instead of dropping to 0
  logic [8:0]           rd_hold_q, rd_hold_d;
  logic [8:0]           wr_addr_hold_q, wr_addr_hold_d;
  logic [COUNT_W-1:0]   wr_data_hold_q, wr_data_hold_d;

  logic [COUNT_W-1:0]   bin_count, bin_next;

  // Next-state logic: start is only looked at in IDLE, so requests while busy drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef HISTOGRAM_BUILDER_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = RUN;
`endif
        end
      end
      CLEAR:  if (clr_cnt_q == 8'hFF) state_d = RUN;
      RUN:    if (pix_cnt_q == LAST_ADDR) state_d = DRAIN;
      // Last write is in flight when only stage 2 is still valid
      DRAIN:  if (v2_q && !v1_q && !iss_q) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue side: bank capture on acceptance, clear sweep, M1 address stream
  always_comb begin
    bank_d    = bank_q;
    clr_cnt_d = clr_cnt_q;
    clr_k_d   = clr_k_q;
    clr_we_d  = 1'b0;
    pix_cnt_d = pix_cnt_q;
    m1_addr_d = m1_addr_q;
    iss_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bank_d    = input_base_offset;
          clr_cnt_d = 8'd0;
          pix_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_we_d  = 1'b1;
        clr_k_d   = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 8'd1;
      end
      RUN: begin
        iss_d     = 1'b1;
        m1_addr_d = pix_cnt_q;
        pix_cnt_d = pix_cnt_q + M1_ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // Read-modify-write datapath. M2 returns pre-write data on a same-cycle
  // read/write collision, so the value written alongside a matching read is
  // captured and used in place of m2_read_data one cycle later.
  always_comb begin
    bin_count      = fwd_v_q ? fwd_val_q : m2_read_data;
    bin_next       = (bin_count == COUNT_MAX) ? bin_count : bin_count + COUNT_W'(1);
    pix2_d         = v1_q ? m1_read_data : pix2_q;
    fwd_v_d        = v1_q && v2_q && (m1_read_data == pix2_q);
    fwd_val_d      = bin_next;
    rd_hold_d      = m2_read_addr;
    wr_addr_hold_d = m2_write_addr;
    wr_data_hold_d = m2_write_data;
  end

  assign m1_read_addr  = m1_addr_q;
  assign m2_read_addr  = v1_q ? {bank_q, m1_read_data} : rd_hold_q;
  assign m2_write_en   = clr_we_q | v2_q;
  assign m2_write_addr = clr_we_q ? {bank_q, clr_k_q} :
                         v2_q     ? {bank_q, pix2_q}  : wr_addr_hold_q;
  assign m2_write_data = clr_we_q ? '0 :
                         v2_q     ? bin_next : wr_data_hold_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FINISH);

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers; reset drops all valids so an aborted job writes nothing more
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_q         <= 1'b0;
      clr_cnt_q      <= 8'd0;
      clr_k_q        <= 8'd0;
      clr_we_q       <= 1'b0;
      pix_cnt_q      <= '0;
      m1_addr_q      <= '0;
      iss_q          <= 1'b0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      pix2_q         <= 8'd0;
      fwd_v_q        <= 1'b0;
      fwd_val_q      <= '0;
      rd_hold_q      <= 9'd0;
      wr_addr_hold_q <= 9'd0;
      wr_data_hold_q <= '0;
    end else begin
      bank_q         <= bank_d;
      clr_cnt_q      <= clr_cnt_d;
      clr_k_q        <= clr_k_d;
      clr_we_q       <= clr_we_d;
      pix_cnt_q      <= pix_cnt_d;
      m1_addr_q      <= m1_addr_d;
      iss_q          <= iss_d;
      v1_q           <= iss_q;
      v2_q           <= v1_q;
      pix2_q         <= pix2_d;
      fwd_v_q        <= fwd_v_d;
      fwd_val_q      <= fwd_val_d;
      rd_hold_q      <= rd_hold_d;
      wr_addr_hold_q <= wr_addr_hold_d;
      wr_data_hold_q <= wr_data_hold_d;
    end
  end

endmodule

// File: tb/tb_histogram_builder.sv
// Directed bench for histogram_builder with PIXEL_COUNT=8. M1 and M2 are
// modelled as one-cycle-latency memories; M2 returns pre-write data on a
// same-cycle collision. Timing expectations follow HISTOGRAM_BUILDER_CLEAR_EN.
`timescale 1ns/1ps
module tb_histogram_builder;
  localparam int P = 8;
`ifdef HISTOGRAM_BUILDER_CLEAR_EN
  localparam int CLR_CYC   = 256;
  localparam int RESTART_C = 100;
`else
  localparam int CLR_CYC   = 0;
  localparam int RESTART_C = 5;
`endif
  localparam int E_DONE  = CLR_CYC + 3 + P;
  localparam int ABORT_C = CLR_CYC + 6;
  localparam int LAST_C  = E_DONE + 4;

  // Clock/reset and DUT signals
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        input_base_offset = 1'b0;
  logic [7:0]  m1_read_data = 8'd0;
  logic [19:0] m1_read_addr;
  logic [19:0] m2_read_data = 20'd0;
  logic [8:0]  m2_read_addr, m2_write_addr;
  logic [19:0] m2_write_data;
  logic        m2_write_en, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  histogram_builder #(.PIXEL_COUNT(P), .COUNT_W(20), .M1_ADDR_W(20)) dut (
    .clock(clock), .reset(reset), .start(start),
    .input_base_offset(input_base_offset),
    .m1_read_data(m1_read_data), .m1_read_addr(m1_read_addr),
    .m2_read_data(m2_read_data), .m2_read_addr(m2_read_addr),
    .m2_write_addr(m2_write_addr), .m2_write_data(m2_write_data),
    .m2_write_en(m2_write_en), .busy(busy), .done(done)
  );

  // Memory models
  logic [7:0]  m1_mem [0:P-1];
  logic [19:0] m2_mem [0:511];
  always @(posedge clock) begin
    m1_read_data <= m1_mem[m1_read_addr[2:0]];
    m2_read_data <= m2_mem[m2_read_addr];
    if (m2_write_en) m2_mem[m2_write_addr] <= m2_write_data;
  end

  // Observation logs and scoreboard
  logic [8:0]  pipe_a[$];
  logic [19:0] pipe_d[$];
  int          pipe_c[$];
  logic [8:0]  clr_a[$];
  logic [19:0] clr_d[$];
  int          clr_c[$];
  logic [19:0] exp_q[$];
  bit          busy_log [0:299];
  int          done_n, done_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m1a"}, m1_read_addr, 0);
    check({tag, "_m2ra"}, m2_read_addr, 0);
    check({tag, "_m2wa"}, m2_write_addr, 0);
    check({tag, "_m2wd"}, m2_write_data, 0);
    check({tag, "_m2we"}, m2_write_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic load_pix(input logic [63:0] px);
    for (int p = 0; p < P; p++) m1_mem[p] = px[8*p +: 8];
  endtask

  // Junk when the block clears its bank itself, zero otherwise
  task automatic prep_m2();
    for (int i = 0; i < 512; i++) begin
`ifdef HISTOGRAM_BUILDER_CLEAR_EN
      m2_mem[i] = 20'h5A5A5;
`else
      m2_mem[i] = 20'd0;
`endif
    end
  endtask

  // Start a job at edge 0 and observe cycles 0..LAST_C at each falling edge
  task automatic run_job(input logic bank, input int restart_c, input int abort_c);
    pipe_a.delete(); pipe_d.delete(); pipe_c.delete();
    clr_a.delete(); clr_d.delete(); clr_c.delete();
    done_n = 0;
    done_c = -1;
    for (int i = 0; i < 300; i++) busy_log[i] = 1'b0;
    @(negedge clock);
    start = 1'b1;
    input_base_offset = bank;
    for (int c = 0; c <= LAST_C; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == restart_c) begin
        start = 1'b1;
        input_base_offset = ~bank;
      end
      busy_log[c] = busy;
      if (done) begin
        done_n++;
        done_c = c;
      end
      if (m2_write_en) begin
        if (c <= CLR_CYC) begin
          clr_a.push_back(m2_write_addr); clr_d.push_back(m2_write_data); clr_c.push_back(c);
        end else begin
          pipe_a.push_back(m2_write_addr); pipe_d.push_back(m2_write_data); pipe_c.push_back(c);
        end
      end
      if (c == abort_c) begin
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
      end else if (reset) begin
        reset = 1'b0;
      end
    end
    start = 1'b0;
    input_base_offset = 1'b0;
  endtask

  int n;

  initial begin
    // Reset state
    @(negedge clock);
    check_outputs_zero("rst");
    reset = 1'b0;

    // Distinct pixels 0..7, bank 0
    prep_m2();
    load_pix(64'h07060504_03020100);
    run_job(1'b0, -1, -1);
    check("t1_done_n", done_n, 1);
    check("t1_done_c", done_c, E_DONE);
    check("t1_busy_c0", busy_log[0], 1);
    check("t1_busy_done", busy_log[E_DONE], 1);
    check("t1_busy_after", busy_log[E_DONE+1], 0);
    check("t1_nwrites", pipe_a.size(), P);
    for (int p = 0; p < P; p++) begin
      check("t1_wcyc", pipe_c[p], CLR_CYC + 3 + p);
      check("t1_waddr", pipe_a[p], p);
      check("t1_wdata", pipe_d[p], 1);
      check("t1_bin", m2_mem[p], 1);
    end
    n = 0;
    for (int b = P; b < 256; b++) if (m2_mem[b] != 20'd0) n++;
    check("t1_other_bins_zero", n, 0);
`ifdef HISTOGRAM_BUILDER_CLEAR_EN
    check("t1_nclear", clr_a.size(), 256);
    n = 0;
    for (int k = 0; k < 256; k++)
      if (clr_c[k] == k + 1 && clr_a[k] == 9'(k) && clr_d[k] == 20'd0) n++;
    check("t1_clear_seq", n, 256);
`endif

    // All pixels 5: same-bin back-to-back writes need forwarding
    prep_m2();
    load_pix(64'h05050505_05050505);
    run_job(1'b0, -1, -1);
    check("t2_bin5", m2_mem[5], 8);
    check("t2_nwrites", pipe_a.size(), P);
    for (int i = 1; i <= P; i++) exp_q.push_back(20'(i));
    for (int p = 0; p < P; p++) begin
      check("t2_waddr", pipe_a[p], 5);
      check("t2_wdata", pipe_d[p], exp_q.pop_front());
    end
    check("t2_done_c", done_c, E_DONE);

    // Pattern 3,3,4,3 then 10..13, bank 1
    prep_m2();
    load_pix(64'h0D0C0B0A_03040303);
    run_job(1'b1, -1, -1);
    check("t3_bin259", m2_mem[259], 3);
    check("t3_bin260", m2_mem[260], 1);
    check("t3_bin266", m2_mem[266], 1);
    n = 0;
    foreach (pipe_a[i]) if (pipe_a[i] < 9'd256) n++;
    foreach (clr_a[i]) if (clr_a[i] < 9'd256) n++;
    check("t3_low_writes", n, 0);
    check("t3_done_c", done_c, E_DONE);

    // Second start while busy, with bank flipped, must be ignored
    prep_m2();
    load_pix(64'h00070707_02020101);
    run_job(1'b0, RESTART_C, -1);
    check("t4_done_n", done_n, 1);
    check("t4_done_c", done_c, E_DONE);
    check("t4_bin0", m2_mem[0], 1);
    check("t4_bin1", m2_mem[1], 2);
    check("t4_bin2", m2_mem[2], 2);
    check("t4_bin7", m2_mem[7], 3);
    n = 0;
    foreach (pipe_a[i]) if (pipe_a[i] >= 9'd256) n++;
    foreach (clr_a[i]) if (clr_a[i] >= 9'd256) n++;
    check("t4_bank1_writes", n, 0);
    check("t4_busy_after", busy_log[E_DONE+1], 0);

    // Reset mid-scan aborts, then a fresh job completes
    prep_m2();
    load_pix(64'h07060504_03020100);
    run_job(1'b0, -1, ABORT_C);
    n = 0;
    foreach (pipe_c[i]) if (pipe_c[i] > ABORT_C) n++;
    check("t5_writes_after_abort", n, 0);
    check("t5_done_n", done_n, 0);
    prep_m2();
    run_job(1'b0, -1, -1);
    check("t5_rerun_done_n", done_n, 1);
    check("t5_rerun_done_c", done_c, E_DONE);
    n = 0;
    for (int b = 0; b < P; b++) if (m2_mem[b] == 20'd1) n++;
    check("t5_rerun_bins", n, P);

`ifndef HISTOGRAM_BUILDER_CLEAR_EN
    // Saturation from a preloaded bin
    prep_m2();
    m2_mem[9] = 20'hFFFFE;
    load_pix(64'h06040302_09010909);
    run_job(1'b0, -1, -1);
    check("t6_bin9", m2_mem[9], 20'hFFFFF);
    check("t6_bin1", m2_mem[1], 1);
    n = 0;
    foreach (pipe_a[i]) if (pipe_a[i] == 9'd9 && pipe_d[i] == 20'hFFFFF) n++;
    check("t6_sat_writes", n, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
